// File: rtl/find_first_one_index_rr_pkg.sv
// find_first_one_index_rr_pkg: mode constants and index-width legality check
package find_first_one_index_rr_pkg;
  localparam logic FFO_MODE_FIXED = 1'b0;
  localparam logic FFO_MODE_RR = 1'b1;
  function automatic bit index_width_ok(int vector_length, int index_width);
    return vector_length >= 2 && (1 << index_width) >= vector_length;
  endfunction
endpackage

// File: rtl/find_highest_one.sv
// find_highest_one: combinational encoder for the highest set bit of a vector
module find_highest_one #(
  parameter int VECTOR_LENGTH = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic [VECTOR_LENGTH-1:0] vector_in,
  output logic [INDEX_WIDTH-1:0]   index_out,
  output logic                     found_out
);
  // scan upward so the highest set bit is the last one to write the index
  always_comb begin
    index_out = '0;
    found_out = 1'b0;
    for (int i = 0; i < VECTOR_LENGTH; i++) begin
      if (vector_in[i]) begin
        index_out = INDEX_WIDTH'(i);
        found_out = 1'b1;
      end
    end
  end
endmodule

// File: rtl/find_first_one_index_rr.sv
// find_first_one_index_rr: registered, handshaked highest-set-bit finder with optional round robin
module find_first_one_index_rr
  import find_first_one_index_rr_pkg::*;
#(
  parameter int VECTOR_LENGTH = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [VECTOR_LENGTH-1:0] vector_in,
  input  logic                     vector_valid_in,
  output logic                     vector_ready_out,
  input  logic                     round_robin_mode_in,
  output logic [INDEX_WIDTH-1:0]   index_out,
  output logic                     found_out,
  output logic                     index_valid_out,
  input  logic                     index_ready_in
);
  if (!index_width_ok(VECTOR_LENGTH, INDEX_WIDTH)) begin : g_bad_width
    $error("INDEX_WIDTH too small for VECTOR_LENGTH");
  end
  logic [INDEX_WIDTH-1:0] last_index_q, last_index_d, index_q, index_d, masked_index, raw_index, sel_index;
  logic found_q, found_d, valid_q, valid_d, masked_found, raw_found, rr, accept;
  logic [VECTOR_LENGTH-1:0] mask;
  find_highest_one #(.VECTOR_LENGTH(VECTOR_LENGTH), .INDEX_WIDTH(INDEX_WIDTH)) u_masked (
    .vector_in(vector_in & mask),
    .index_out(masked_index),
    .found_out(masked_found)
  );
  find_highest_one #(.VECTOR_LENGTH(VECTOR_LENGTH), .INDEX_WIDTH(INDEX_WIDTH)) u_raw (
    .vector_in(vector_in),
    .index_out(raw_index),
    .found_out(raw_found)
  );
  // masked search below last grant wins in round robin; raw search is the wrap and fixed-priority result
  always_comb begin
    mask = (VECTOR_LENGTH'(1) << last_index_q) - VECTOR_LENGTH'(1);
    rr = round_robin_mode_in == FFO_MODE_RR;
    sel_index = rr && masked_found ? masked_index : raw_index;
    vector_ready_out = ~valid_q | index_ready_in;
    accept = vector_valid_in & vector_ready_out;
    valid_d = accept ? 1'b1 : (index_ready_in ? 1'b0 : valid_q);
    index_d = accept ? sel_index : index_q;
    found_d = accept ? raw_found : found_q;
    last_index_d = accept && rr && raw_found ? sel_index : last_index_q;
  end
  // one-entry output register plus round-robin pointer
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_q <= 1'b0;
      index_q <= '0;
      found_q <= 1'b0;
      last_index_q <= '0;
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
      found_q <= found_d;
      last_index_q <= last_index_d;
    end
  end
  assign index_out = index_q;
  assign found_out = found_q;
  assign index_valid_out = valid_q;
endmodule

// File: tb/tb_find_first_one_index_rr.sv
// tb_find_first_one_index_rr: scoreboard bench with directed vectors for find_first_one_index_rr
module tb_find_first_one_index_rr;
  import find_first_one_index_rr_pkg::*;
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic [7:0] vector_in = '0;
  logic vector_valid_in = 1'b0;
  logic vector_ready_out;
  logic round_robin_mode_in = FFO_MODE_FIXED;
  logic [2:0] index_out;
  logic found_out;
  logic index_valid_out;
  logic index_ready_in = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  find_first_one_index_rr #(.VECTOR_LENGTH(8), .INDEX_WIDTH(3)) dut (
    .clk_in(clk),
    .reset_in(reset_in),
    .vector_in(vector_in),
    .vector_valid_in(vector_valid_in),
    .vector_ready_out(vector_ready_out),
    .round_robin_mode_in(round_robin_mode_in),
    .index_out(index_out),
    .found_out(found_out),
    .index_valid_out(index_valid_out),
    .index_ready_in(index_ready_in)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset_in && index_valid_out && index_ready_in) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("result{index,found}", {index_out, found_out}, exp_q.pop_front());
    end
  end
  task automatic push(input logic [7:0] v, input logic mode, input int idx, input logic fnd);
    bit ok = 0;
    vector_in = v;
    round_robin_mode_in = mode;
    vector_valid_in = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = vector_ready_out;
    end
    if (ok) exp_q.push_back({3'(idx), fnd});
    else chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 vector_valid_in = 1'b0;
  endtask
  task automatic do_reset();
    reset_in = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset_in = 1'b0;
  endtask
  initial begin
    #200000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset_in = 1'b0;
    @(negedge clk);
    chk("reset_valid", index_valid_out, 0);
    chk("reset_index", index_out, 0);
    chk("reset_found", found_out, 0);
    chk("reset_ready", vector_ready_out, 1);
    @(posedge clk);
    #1;
    push(8'h26, FFO_MODE_FIXED, 5, 1);
    chk("fixed_latency_valid", index_valid_out, 1);
    chk("fixed_latency_index", index_out, 5);
    push(8'h26, FFO_MODE_RR, 5, 1);
    push(8'h26, FFO_MODE_RR, 2, 1);
    push(8'h26, FFO_MODE_RR, 1, 1);
    push(8'h26, FFO_MODE_RR, 5, 1);
    push(8'h26, FFO_MODE_RR, 2, 1);
    push(8'h00, FFO_MODE_RR, 0, 0);
    push(8'h06, FFO_MODE_RR, 1, 1);
    push(8'h80, FFO_MODE_RR, 7, 1);
    index_ready_in = 1'b0;
    vector_in = 8'h26;
    round_robin_mode_in = FFO_MODE_RR;
    vector_valid_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", vector_ready_out, 0);
      chk("bp_valid", index_valid_out, 1);
      chk("bp_index", index_out, 7);
      chk("bp_found", found_out, 1);
    end
    @(posedge clk);
    #1 index_ready_in = 1'b1;
    push(8'h26, FFO_MODE_RR, 5, 1);
    chk("bp_new_result", index_out, 5);
    index_ready_in = 1'b0;
    @(posedge clk);
    #1 do_reset();
    chk("midreset_valid", index_valid_out, 0);
    chk("midreset_index", index_out, 0);
    chk("midreset_found", found_out, 0);
    index_ready_in = 1'b1;
    push(8'h26, FFO_MODE_RR, 5, 1);
    do_reset();
    push(8'h26, FFO_MODE_RR, 5, 1);
    push(8'h26, FFO_MODE_FIXED, 5, 1);
    push(8'h26, FFO_MODE_RR, 2, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_valid", index_valid_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
